lsu_mem_port: RTL

- Load/store front end that drives the 8-lane MMU request bus and collects its read data.
- Accepts one vector command per handshake from the core: a store (up to 8 lane writes) or a load (8 consecutive words).
- Turns each command into `write_req_pkt[8]` beats, holds them stable while the MMU stalls, and captures read data one cycle after a read is issued.
- Enforces in hardware the no-read-while-writes-in-flight rule, instead of relying on the assembler.

---
 rtl/memory_pkg.sv | 37 +++
 rtl/lsu_mem_port_if.sv | 33 +++
 rtl/lsu_req_gen.sv | 28 ++
 rtl/lsu_mem_port.sv | 120 ++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the LSU <-> MMU request path.
package memory_pkg;

  localparam int unsigned LSU_LANES        = 8;
  localparam int unsigned LSU_ADDR_W       = 18;
  localparam int unsigned LSU_DATA_W       = 9;
  localparam int unsigned LSU_DRAIN_CYCLES = 6;

  typedef logic [LSU_ADDR_W-1:0] addr_t;
  typedef logic [LSU_DATA_W-1:0] data_t;
  typedef logic [LSU_LANES-1:0]  mask_t;
  typedef data_t [LSU_LANES-1:0] lane_data_t;

  typedef struct packed {
    logic  en;
    addr_t addr;
    data_t data;
    logic  forcewrite;
  } write_req_pkt;

  typedef write_req_pkt [LSU_LANES-1:0] req_bus_t;

  typedef enum logic [2:0] {
    StIdle,
    StStIssue,
    StLdWait,
    StLdIssue,
    StLdCapt,
    StResp
  } lsu_state_e;

  // Lane address wraps modulo 2^LSU_ADDR_W.
  function automatic addr_t lane_addr(addr_t base, int unsigned lane);
    return base + addr_t'(lane);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Command, response and MMU request signals of the LSU memory port.
interface lsu_mem_port_if;
  import memory_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_is_store;
  addr_t      cmd_base_addr;
  mask_t      cmd_lane_mask;
  logic       cmd_forcewrite;
  lane_data_t cmd_store_data;

  logic       rsp_valid;
  logic       rsp_ready;
  lane_data_t rsp_data;

  req_bus_t   mmu_write_reqs;
  logic       mmu_stall;
  lane_data_t mmu_read_data;

  modport master (
    input  cmd_valid, cmd_is_store, cmd_base_addr, cmd_lane_mask, cmd_forcewrite,
           cmd_store_data, rsp_ready, mmu_stall, mmu_read_data,
    output cmd_ready, rsp_valid, rsp_data, mmu_write_reqs
  );

  modport slave (
    output cmd_valid, cmd_is_store, cmd_base_addr, cmd_lane_mask, cmd_forcewrite,
           cmd_store_data, rsp_ready, mmu_stall, mmu_read_data,
    input  cmd_ready, rsp_valid, rsp_data, mmu_write_reqs
  );

endinterface

// File: rtl/lsu_req_gen.sv
// Combinational builder of the per-lane MMU request packets from the registered command.
module lsu_req_gen
  import memory_pkg::*;
(
  input  lsu_state_e state_i,
  input  addr_t      base_i,
  input  mask_t      mask_i,
  input  logic       fw_i,
  input  lane_data_t data_i,
  output req_bus_t   reqs_o
);

  always_comb begin
    reqs_o = '0;
    for (int unsigned i = 0; i < LSU_LANES; i++) begin
      if (state_i == StStIssue) begin
        reqs_o[i].en         = mask_i[i];
        reqs_o[i].addr       = lane_addr(base_i, i);
        reqs_o[i].data       = data_i[i];
        reqs_o[i].forcewrite = fw_i;
      end else if (state_i == StLdIssue) begin
        // A read is an address with en low; data and forcewrite stay zero.
        reqs_o[i].addr = lane_addr(base_i, i);
      end
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU front end: turns vector load/store commands into MMU request beats and
// gates loads until previously accepted stores have drained through the MMU queue.
module lsu_mem_port
  import memory_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = LSU_DRAIN_CYCLES
) (
  input logic            clk,
  input logic            rst_n,
  lsu_mem_port_if.master port_io
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] drain_q, drain_d;
  addr_t           base_q, base_d;
  mask_t           mask_q, mask_d;
  logic            fw_q, fw_d;
  lane_data_t      data_q, data_d;
  logic            rsp_valid_q, rsp_valid_d;
  lane_data_t      rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mask_d      = mask_q;
    fw_d        = fw_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    drain_d     = (drain_q != '0) ? drain_q - CntW'(1) : drain_q;

    unique case (state_q)
      StIdle: begin
        if (port_io.cmd_valid) begin
          base_d = port_io.cmd_base_addr;
          mask_d = port_io.cmd_lane_mask;
          fw_d   = port_io.cmd_forcewrite;
          data_d = port_io.cmd_store_data;
          if (port_io.cmd_is_store) begin
            state_d = StStIssue;
          end else if (drain_q == '0 && !port_io.mmu_stall) begin
            state_d = StLdIssue;
          end else begin
            state_d = StLdWait;
          end
        end
      end
      StStIssue: begin
        // Reload wins over the decrement so the drain window starts at this beat.
        if (!port_io.mmu_stall) begin
          drain_d = DrainLoad;
          state_d = StIdle;
        end
      end
      StLdWait: begin
        if (drain_q == '0 && !port_io.mmu_stall) begin
          state_d = StLdIssue;
        end
      end
      StLdIssue: begin
        state_d = StLdCapt;
      end
      StLdCapt: begin
        for (int unsigned i = 0; i < LSU_LANES; i++) begin
          rsp_data_d[i] = mask_q[i] ? port_io.mmu_read_data[i] : '0;
        end
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (port_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drain_q     <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      fw_q        <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
      fw_q        <= fw_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  lsu_req_gen u_req_gen (
    .state_i (state_q),
    .base_i  (base_q),
    .mask_i  (mask_q),
    .fw_i    (fw_q),
    .data_i  (data_q),
    .reqs_o  (port_io.mmu_write_reqs)
  );

  assign port_io.cmd_ready = (state_q == StIdle);
  assign port_io.rsp_valid = rsp_valid_q;
  assign port_io.rsp_data  = rsp_data_q;

endmodule
